// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access sequencer: FSM states, operation
// kind and the wait-counter width.
package mem_ctrl_pkg;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response and RAM-side port bundle of the sequencer.
// slave is the sequencer's view, master the view of the surrounding system.
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  read_req;
    logic                  write_req;
    logic [ADDR_WIDTH-1:0] mar_addr;
    logic [DATA_WIDTH-1:0] mdr_wdata;
    logic [DATA_WIDTH-1:0] mdr_rdata;
    logic                  mem_done;
    logic                  busy;
    logic                  mem_err;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  read_req, write_req, mar_addr, mdr_wdata, ram_rdata,
        output mdr_rdata, mem_done, busy, mem_err,
               ram_addr, ram_wdata, ram_re, ram_we
    );

    modport master (
        output read_req, write_req, mar_addr, mdr_wdata, ram_rdata,
        input  mdr_rdata, mem_done, busy, mem_err,
               ram_addr, ram_wdata, ram_re, ram_we
    );
endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module wait_counter
    import mem_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  dec,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  zero
);
    logic [WAIT_CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && !zero) begin
            count_reg <= count_reg - WAIT_CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer between MAR/MDR and a word-addressed RAM.
// Optional address bounds checking: MEM_ACCESS_CTRL_BOUNDS_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_SIZE    = 512
) (
    input  logic            clock,
    input  logic            clear,
    mem_access_ctrl_if.slave bus
);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                state_reg, state_next;
    op_t                   op_reg, op_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  re_reg, re_next;
    logic                  we_reg, we_next;
    logic                  done_reg, done_next;
    logic                  busy_reg, busy_next;

    logic                  req_take;
    logic                  last_access;
    logic                  addr_oob;
    logic                  oob_q;
    logic [WAIT_CNT_W-1:0] wait_count;
    logic                  wait_zero;

    assign req_take    = (state_reg == IDLE) && (bus.read_req || bus.write_req);
    assign last_access = (state_reg == ACCESS) && wait_zero;

    wait_counter u_wait_counter (
        .clock    (clock),
        .clear    (clear),
        .load     (req_take),
        .dec      (state_reg == ACCESS),
        .load_val (WAIT_LOAD),
        .count    (wait_count),
        .zero     (wait_zero)
    );

`ifdef MEM_ACCESS_CTRL_BOUNDS_EN
    logic oob_reg;
    logic err_reg;

    assign addr_oob = (32'(bus.mar_addr) >= 32'(MEM_SIZE));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            oob_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            if (req_take) begin
                oob_reg <= addr_oob;
            end
            err_reg <= last_access && oob_reg;
        end
    end

    assign oob_q       = oob_reg;
    assign bus.mem_err = err_reg;
`else
    assign addr_oob    = 1'b0;
    assign oob_q       = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_take) state_next = ACCESS;
            ACCESS:  if (wait_zero) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs. The write strobe
    // is issued one edge early so it lands in the final ACCESS cycle.
    always_comb begin
        op_next    = op_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        re_next    = 1'b0;
        we_next    = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_take) begin
                    op_next    = bus.read_req ? OP_READ : OP_WRITE;
                    addr_next  = bus.mar_addr;
                    wdata_next = bus.mdr_wdata;
                    re_next    = bus.read_req && !addr_oob;
                    we_next    = !bus.read_req && (WAIT_CYCLES == 0) && !addr_oob;
                end
            end
            ACCESS: begin
                if (wait_zero) begin
                    done_next = 1'b1;
                    if (op_reg == OP_READ) begin
                        rdata_next = oob_q ? '0 : bus.ram_rdata;
                    end
                end else begin
                    re_next = (op_reg == OP_READ) && !oob_q;
                    we_next = (op_reg == OP_WRITE) && !oob_q
                              && (wait_count == WAIT_CNT_W'(1));
                end
            end
            default: ;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_reg    <= OP_READ;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            re_reg    <= 1'b0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            re_reg    <= re_next;
            we_reg    <= we_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign bus.ram_addr  = addr_reg;
    assign bus.ram_wdata = wdata_reg;
    assign bus.ram_re    = re_reg;
    assign bus.ram_we    = we_reg;
    assign bus.mdr_rdata = rdata_reg;
    assign bus.mem_done  = done_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: dut1 (WAIT_CYCLES=1, MEM_SIZE=512), dut0 (WAIT_CYCLES=0, MEM_SIZE=256).
module tb_mem_access_ctrl;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus1 ();
    mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus0 ();

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_CYCLES(1), .MEM_SIZE(512))
        dut1 (.clock(clock), .clear(clear), .bus(bus1));
    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WAIT_CYCLES(0), .MEM_SIZE(256))
        dut0 (.clock(clock), .clear(clear), .bus(bus0));

    // Asynchronous-read RAM models; contents are reloaded while clear is low.
    logic [31:0] ram1 [0:511];
    logic [31:0] ram0 [0:511];
    assign bus1.ram_rdata = ram1[bus1.ram_addr];
    assign bus0.ram_rdata = ram0[bus0.ram_addr];

    always @(posedge clock) begin
        if (!clear) begin
            ram1[9'h010] = 32'hDEADBEEF;
            ram1[9'h020] = 32'hA5A50020;
            ram1[9'h1FF] = 32'h00000000;
            ram0[9'h005] = 32'hCAFE0005;
            ram0[9'h100] = 32'h0BAD0100;
        end else begin
            if (bus1.ram_we) ram1[bus1.ram_addr] = bus1.ram_wdata;
            if (bus0.ram_we) ram0[bus0.ram_addr] = bus0.ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int sel, input bit rd, input bit wr,
                           input logic [8:0] addr, input logic [31:0] wd);
        if (sel == 1) begin
            bus1.read_req = rd; bus1.write_req = wr; bus1.mar_addr = addr; bus1.mdr_wdata = wd;
        end else begin
            bus0.read_req = rd; bus0.write_req = wr; bus0.mar_addr = addr; bus0.mdr_wdata = wd;
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge
    // after the one showing mem_done.
    task automatic access(input int sel, input bit rd, input bit wr,
                          input logic [8:0] addr, input logic [31:0] wd,
                          output int lat, output int re_n, output int we_n,
                          output logic [31:0] rdata, output logic err);
        bit seen = 1'b0;
        lat = 0; re_n = 0; we_n = 0; rdata = '0; err = 1'b0;
        set_req(sel, rd, wr, addr, wd);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            lat++;
            if (i == 0) set_req(sel, 1'b0, 1'b0, addr, wd);
            if ((sel == 1) ? bus1.ram_re : bus0.ram_re) re_n++;
            if ((sel == 1) ? bus1.ram_we : bus0.ram_we) we_n++;
            if ((sel == 1) ? bus1.mem_done : bus0.mem_done) begin
                seen  = 1'b1;
                rdata = (sel == 1) ? bus1.mdr_rdata : bus0.mdr_rdata;
                err   = (sel == 1) ? bus1.mem_err : bus0.mem_err;
            end
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
        @(negedge clock);
        check("done_one_cycle", {31'd0, (sel == 1) ? bus1.mem_done : bus0.mem_done}, 32'd0);
        check("busy_after_done", {31'd0, (sel == 1) ? bus1.busy : bus0.busy}, 32'd0);
        $display("txn dut%0d rd=%0b wr=%0b addr=0x%03h wd=0x%08h lat=%0d re=%0d we=%0d rdata=0x%08h err=%0b",
                 sel, rd, wr, addr, wd, lat, re_n, we_n, rdata, err);
    endtask

    int          lat, re_n, we_n, dn;
    logic [31:0] rdata;
    logic        err;
    logic [11:0] done_vec, busy_lo_vec;

    initial begin
        set_req(1, 1'b0, 1'b0, 9'h0, 32'h0);
        set_req(0, 1'b0, 1'b0, 9'h0, 32'h0);
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_mdr_rdata", bus1.mdr_rdata, 32'h0);
        check("rst_ram_addr",  {23'd0, bus1.ram_addr}, 32'h0);
        check("rst_ram_wdata", bus1.ram_wdata, 32'h0);
        check("rst_flags", {27'd0, bus1.mem_done, bus1.busy, bus1.mem_err, bus1.ram_re, bus1.ram_we}, 32'h0);
        check("rst_flags0", {27'd0, bus0.mem_done, bus0.busy, bus0.mem_err, bus0.ram_re, bus0.ram_we}, 32'h0);
        clear = 1'b1;
        @(negedge clock);

        // Single read, WAIT_CYCLES=1
        access(1, 1'b1, 1'b0, 9'h010, 32'h0, lat, re_n, we_n, rdata, err);
        check("rd_latency", lat, 32'd3);
        check("rd_re_cycles", re_n, 32'd2);
        check("rd_we_cycles", we_n, 32'd0);
        check("rd_data", rdata, 32'hDEADBEEF);
        check("rd_err", {31'd0, err}, 32'd0);

        // Write then read back
        access(1, 1'b0, 1'b1, 9'h1FF, 32'h12345678, lat, re_n, we_n, rdata, err);
        check("wr_latency", lat, 32'd3);
        check("wr_we_cycles", we_n, 32'd1);
        check("wr_re_cycles", re_n, 32'd0);
        check("wr_keeps_mdr", rdata, 32'hDEADBEEF);
        access(1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, re_n, we_n, rdata, err);
        check("rdback_data", rdata, 32'h12345678);

        // Simultaneous requests: read wins
        access(1, 1'b1, 1'b1, 9'h020, 32'hFFFF0000, lat, re_n, we_n, rdata, err);
        check("both_data", rdata, 32'hA5A50020);
        check("both_we_cycles", we_n, 32'd0);
        check("both_re_cycles", re_n, 32'd2);
        dn = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus1.mem_done) dn++;
        end
        check("both_single_done", dn, 32'd0);

        // Reset in the middle of a read
        set_req(1, 1'b1, 1'b0, 9'h010, 32'h0);
        @(negedge clock);
        set_req(1, 1'b0, 1'b0, 9'h010, 32'h0);
        check("mid_rst_re_before", {31'd0, bus1.ram_re}, 32'd1);
        #2 clear = 1'b0;
        #1;
        check("mid_rst_re", {31'd0, bus1.ram_re}, 32'd0);
        check("mid_rst_we", {31'd0, bus1.ram_we}, 32'd0);
        check("mid_rst_busy", {31'd0, bus1.busy}, 32'd0);
        check("mid_rst_mdr", bus1.mdr_rdata, 32'h0);
        @(negedge clock);
        clear = 1'b1;
        dn = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus1.mem_done) dn++;
        end
        check("mid_rst_no_done", dn, 32'd0);
        check("mid_rst_mdr_hold", bus1.mdr_rdata, 32'h0);
        access(1, 1'b1, 1'b0, 9'h010, 32'h0, lat, re_n, we_n, rdata, err);
        check("post_rst_data", rdata, 32'hDEADBEEF);
        check("post_rst_latency", lat, 32'd3);

        // WAIT_CYCLES=0 read, then bounds behaviour at 0x100 with MEM_SIZE=256
        access(0, 1'b1, 1'b0, 9'h005, 32'h0, lat, re_n, we_n, rdata, err);
        check("w0_latency", lat, 32'd2);
        check("w0_re_cycles", re_n, 32'd1);
        check("w0_data", rdata, 32'hCAFE0005);
        access(0, 1'b1, 1'b0, 9'h100, 32'h0, lat, re_n, we_n, rdata, err);
        check("bnd_latency", lat, 32'd2);
`ifdef MEM_ACCESS_CTRL_BOUNDS_EN
        check("bnd_err", {31'd0, err}, 32'd1);
        check("bnd_data", rdata, 32'h0);
        check("bnd_re_cycles", re_n, 32'd0);
`else
        check("bnd_err", {31'd0, err}, 32'd0);
        check("bnd_data", rdata, 32'h0BAD0100);
        check("bnd_re_cycles", re_n, 32'd1);
`endif
        check("bnd_err_after", {31'd0, bus0.mem_err}, 32'd0);

        // Back-to-back reads with read_req held, WAIT_CYCLES=0
        done_vec = '0;
        busy_lo_vec = '0;
        set_req(0, 1'b1, 1'b0, 9'h005, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            done_vec[i]    = bus0.mem_done;
            busy_lo_vec[i] = !bus0.busy;
        end
        set_req(0, 1'b0, 1'b0, 9'h005, 32'h0);
        $display("txn dut0 held read addr=0x005 done_vec=%012b busy_lo_vec=%012b", done_vec, busy_lo_vec);
        check("b2b_done_pattern", {20'd0, done_vec}, 32'h492);
        check("b2b_busy_low_pattern", {20'd0, busy_lo_vec}, 32'h924);
        check("b2b_data", bus0.mdr_rdata, 32'hCAFE0005);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Memory access sequencer between the CPU's MAR/MDR datapath and the word-addressed data RAM.
- Accepts a single read or write request, drives the RAM for a configurable number of wait states, then returns read data to the MDR with a one-cycle `mem_done` pulse.
- The control unit stalls on `busy` and advances on `mem_done`; this block is the only driver of the RAM port.

## Interface
- `DATA_WIDTH`, 32, data word width.
- `ADDR_WIDTH`, 9, RAM word-address width.
- `WAIT_CYCLES`, 1, extra RAM access cycles, legal range 0..15.
- `MEM_SIZE`, 512, number of implemented words; used only with bounds checking.
- `clock` input 1: single clock, rising edge.
- `clear` input 1: reset, asynchronous, active-low.
- `read_req` input 1: read request from control unit.
- `write_req` input 1: write request from control unit.
- `mar_addr` input ADDR_WIDTH: address from MAR.
- `mdr_wdata` input DATA_WIDTH: write data from MDR.
- `mdr_rdata` output DATA_WIDTH: registered read data to MDR.
- `mem_done` output 1: one-cycle completion pulse.
- `busy` output 1: high in every state except IDLE.
- `mem_err` output 1: out-of-range flag, valid with `mem_done`.
- `ram_addr` output ADDR_WIDTH: RAM address.
- `ram_wdata` output DATA_WIDTH: RAM write data.
- `ram_re` output 1: RAM read enable.
- `ram_we` output 1: RAM write enable.
- `ram_rdata` input DATA_WIDTH: RAM read data, asynchronous-read RAM.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:** on a rising edge with `read_req` or `write_req` high:
  - Latch `mar_addr`, `mdr_wdata` and the operation type.
  - Load the wait counter with `WAIT_CYCLES` and go to ACCESS.
  - If both requests are high, the read wins and the write is dropped, not queued.
- **ACCESS:**
  - `ram_addr` and `ram_wdata` hold the latched values.
  - For a read, `ram_re` is high for every ACCESS cycle.
  - For a write, `ram_we` is high only in the final ACCESS cycle (counter == 0).
  - The counter decrements each edge. At the edge where it is 0, a read captures `ram_rdata` into `mdr_rdata`, and the FSM goes to DONE.
- **DONE:** `mem_done` is high for exactly one cycle, then the FSM returns to IDLE unconditionally.
- Requests are sampled only in IDLE. Requests asserted during ACCESS or DONE are ignored and must still be high in IDLE to be taken.
- `mdr_rdata` holds its value until the next completed read; writes do not change it.
- Reset values: FSM in IDLE; `mdr_rdata`, `ram_addr` and `ram_wdata` are 0; `mem_done`, `busy`, `mem_err`, `ram_re` and `ram_we` are 0.
- Reset mid-access: `ram_we` and `ram_re` drop asynchronously, no `mem_done` is issued, and the partial read is discarded.

## Timing
- Request sampled at edge k. ACCESS covers cycles k..k+WAIT_CYCLES. `mem_done` is high in the cycle after edge k+WAIT_CYCLES+1.
- Read latency is WAIT_CYCLES+2 edges from request to `mem_done`. `mdr_rdata` is valid in the same cycle `mem_done` is high.
- RAM requirement: `ram_rdata` is valid within WAIT_CYCLES+1 cycles of `ram_re` rising.
- Throughput is at most one access per WAIT_CYCLES+3 cycles, because DONE→IDLE costs one cycle before the next sample.
- All outputs are registered. `busy` rises in the cycle after the request edge.

## Configuration
- Macro: `MEM_ACCESS_CTRL_BOUNDS_EN`.
- **Defined:** when the latched address is ≥ `MEM_SIZE`:
  - The access runs with normal latency, but `ram_re` and `ram_we` stay low.
  - A read loads `mdr_rdata` with 0.
  - `mem_err` is high for the same cycle as `mem_done`.
- **Undefined:** no comparison logic is built; `mem_err` is tied 0 and all addresses go to the RAM.

## Structure
- Package `mem_ctrl_pkg` holds:
  - The state enum (IDLE, ACCESS, DONE).
  - The operation enum (OP_READ, OP_WRITE).
  - The wait-counter width constant, 4 bits.
- Sub-module `wait_counter`: loadable down-counter with a zero flag, instantiated once.

## Test plan
- **Single read:** WAIT_CYCLES=1, RAM[0x010]=0xDEADBEEF, `read_req` pulsed → `ram_re` high for 2 cycles, `mem_done` 3 edges after the request, `mdr_rdata`=0xDEADBEEF.
- **Write then read:** write 0x12345678 to 0x1FF → `ram_we` high exactly 1 cycle; a following read of 0x1FF returns 0x12345678.
- **Simultaneous requests:** `read_req` and `write_req` both high at 0x020 → read performed, `ram_we` never high, one `mem_done`.
- **Reset mid-access:** `clear` low during ACCESS → `ram_re` and `ram_we` fall immediately, no `mem_done`, `mdr_rdata`=0; the next read completes normally.
- **Bounds check:** with macro, MEM_SIZE=256, read of 0x100 → `mem_err`=1 with `mem_done`, `mdr_rdata`=0, `ram_re` never high. Without macro, `mem_err` stays 0.
- **Back-to-back:** WAIT_CYCLES=0, `read_req` held high → one `mem_done` every 3 cycles, `busy` low exactly one cycle between accesses.
